// File: rtl/raycast_pkg.sv
// raycast_pkg: column packet layout and transmit FSM states shared by the DDA
// stream transmitter and the transformation stage that unpacks it.
package raycast_pkg;

    localparam int PKT_W    = 38;
    localparam int COL_LSB  = 29;
    localparam int COL_W    = 9;
    localparam int LH_LSB   = 21;
    localparam int LH_W     = 8;
    localparam int WT_BIT   = 20;
    localparam int MAP_LSB  = 16;
    localparam int MAP_W    = 4;
    localparam int WX_LSB   = 0;
    localparam int WX_W     = 16;

    typedef struct packed {
        logic [COL_W-1:0] column;
        logic [LH_W-1:0]  line_height;
        logic             wall_type;
        logic [MAP_W-1:0] map_data;
        logic [WX_W-1:0]  wall_x;
    } dda_packet_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/dda_stream_tx_fifo.sv
// stream_fifo: synchronous FIFO with registered storage and a combinational head read.
module stream_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/dda_stream_tx.sv
// dda_stream_tx: tags DDA ray results with column indices and streams them out with tlast per frame.
// Define DDA_TX_LINE_CLAMP_EN to clamp line height to SCREEN_HEIGHT before packing.
module dda_stream_tx
    import raycast_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int DEPTH         = 4
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic              ray_valid_in,
    input  logic [7:0]        ray_line_height_in,
    input  logic              ray_wall_type_in,
    input  logic [3:0]        ray_map_data_in,
    input  logic [15:0]       ray_wallX_in,
    output logic              ray_ready_out,
    output logic              dda_fifo_tvalid_out,
    output logic [PKT_W-1:0]  dda_fifo_tdata_out,
    output logic              dda_fifo_tlast_out,
    input  logic              dda_fifo_tready_in,
    output logic              frame_done_out,
    output logic              overflow_err_out
);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(SCREEN_WIDTH - 1);
    localparam logic [LH_W-1:0]  HEIGHT_MAX = LH_W'(SCREEN_HEIGHT);

    if (SCREEN_WIDTH > (1 << COL_W) || SCREEN_HEIGHT >= (1 << LH_W) || DEPTH < 2) begin : g_bad_params
        $error("dda_stream_tx: parameter out of range");
    end

    tx_state_t        state;
    logic [COL_W-1:0] column;
    logic [LH_W-1:0]  line_height;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             last_in;
    logic             head_last;
    dda_packet_t      packet;
    logic [PKT_W:0]   head_word;

`ifdef DDA_TX_LINE_CLAMP_EN
    assign line_height = (ray_line_height_in > HEIGHT_MAX) ? HEIGHT_MAX : ray_line_height_in;
`else
    assign line_height = ray_line_height_in;
`endif

    assign packet = '{
        column:      column,
        line_height: line_height,
        wall_type:   ray_wall_type_in,
        map_data:    ray_map_data_in,
        wall_x:      ray_wallX_in
    };

    assign last_in       = column == LAST_COL;
    assign ray_ready_out = (state == ACTIVE) && !full;
    assign push          = ray_valid_in && ray_ready_out;
    assign pop           = !empty && dda_fifo_tready_in;
    assign head_last     = head_word[PKT_W];

    stream_fifo #(
        .WIDTH(PKT_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (pixel_clk_in),
        .rst  (rst_in),
        .push (push),
        .din  ({last_in, packet}),
        .pop  (pop),
        .dout (head_word),
        .full (full),
        .empty(empty)
    );

    // Gate the head with occupancy so stale storage never leaks onto the bus.
    assign dda_fifo_tvalid_out = !empty;
    assign dda_fifo_tdata_out  = empty ? '0 : head_word[PKT_W-1:0];
    assign dda_fifo_tlast_out  = !empty && head_last;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            column           <= '0;
            frame_done_out   <= 1'b0;
            overflow_err_out <= 1'b0;
        end else begin
            frame_done_out <= pop && head_last;
            if (state == ACTIVE && ray_valid_in && !ray_ready_out) overflow_err_out <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start_in) begin
                        state  <= ACTIVE;
                        column <= '0;
                    end
                end
                ACTIVE: begin
                    if (push) begin
                        column <= last_in ? '0 : column + 1'b1;
                        if (last_in) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && head_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dda_stream_tx.sv
// tb_dda_stream_tx: randomized self-checking bench for dda_stream_tx against a queue-based frame model.
module tb_dda_stream_tx;
    localparam int W = 320;
    localparam int H = 180;
    localparam int D = 4;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        frame_start_in = 1'b0;
    logic        ray_valid_in = 1'b0;
    logic [7:0]  ray_line_height_in = '0;
    logic        ray_wall_type_in = 1'b0;
    logic [3:0]  ray_map_data_in = '0;
    logic [15:0] ray_wallX_in = '0;
    logic        dda_fifo_tready_in = 1'b0;
    logic        ray_ready_out;
    logic        dda_fifo_tvalid_out;
    logic [37:0] dda_fifo_tdata_out;
    logic        dda_fifo_tlast_out;
    logic        frame_done_out;
    logic        overflow_err_out;

    int passed = 0;
    int total = 0;

    always #5 pixel_clk_in = ~pixel_clk_in;

    dda_stream_tx #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .DEPTH(D)) dut (
        .pixel_clk_in       (pixel_clk_in),
        .rst_in             (rst_in),
        .frame_start_in     (frame_start_in),
        .ray_valid_in       (ray_valid_in),
        .ray_line_height_in (ray_line_height_in),
        .ray_wall_type_in   (ray_wall_type_in),
        .ray_map_data_in    (ray_map_data_in),
        .ray_wallX_in       (ray_wallX_in),
        .ray_ready_out      (ray_ready_out),
        .dda_fifo_tvalid_out(dda_fifo_tvalid_out),
        .dda_fifo_tdata_out (dda_fifo_tdata_out),
        .dda_fifo_tlast_out (dda_fifo_tlast_out),
        .dda_fifo_tready_in (dda_fifo_tready_in),
        .frame_done_out     (frame_done_out),
        .overflow_err_out   (overflow_err_out)
    );

    // Frame model: phase of the frame, next column, queue of {last, packet} awaiting delivery.
    typedef enum {M_IDLE, M_ACTIVE, M_FLUSH} mphase_e;
    mphase_e     m_phase = M_IDLE;
    int          m_col = 0;
    logic [38:0] m_q[$];
    bit          m_err = 0;
    bit          m_done = 0;

    function automatic logic [38:0] expect_word(int col, int h, int wt, int mp, int wx);
        longint v;
        int hh = h;
`ifdef DDA_TX_LINE_CLAMP_EN
        if (hh > H) hh = H;
`endif
        v = (longint'(col) << 29) | (longint'(hh) << 21) | (longint'(wt) << 20)
          | (longint'(mp) << 16) | longint'(wx) | (longint'(col == W - 1) << 38);
        return v[38:0];
    endfunction

    task automatic tick();
        bit acc, pop;
        logic [38:0] w;
        acc = (m_phase == M_ACTIVE) && ray_valid_in && (m_q.size() < D);
        pop = (m_q.size() > 0) && dda_fifo_tready_in;
        @(posedge pixel_clk_in);
        m_done = 0;
        if (rst_in) begin
            m_phase = M_IDLE;
            m_col = 0;
            m_q.delete();
            m_err = 0;
        end else begin
            if (m_phase == M_ACTIVE && ray_valid_in && !acc) m_err = 1;
            if (pop) begin
                w = m_q.pop_front();
                m_done = w[38];
            end
            if (acc) begin
                m_q.push_back(expect_word(m_col, ray_line_height_in, ray_wall_type_in,
                                          ray_map_data_in, ray_wallX_in));
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_phase = M_FLUSH;
                end else m_col++;
            end else if (m_phase == M_IDLE && frame_start_in) begin
                m_phase = M_ACTIVE;
                m_col = 0;
            end
            if (m_phase == M_FLUSH && m_done) m_phase = M_IDLE;
        end
        @(negedge pixel_clk_in);
    endtask

    task automatic rand_ray();
        ray_line_height_in = 8'($urandom);
        ray_wall_type_in   = 1'($urandom);
        ray_map_data_in    = 4'($urandom);
        ray_wallX_in       = 16'($urandom);
    endtask

    task automatic do_reset();
        rst_in = 1;
        frame_start_in = 0;
        ray_valid_in = 0;
        dda_fifo_tready_in = 0;
        tick();
        tick();
        rst_in = 0;
    endtask

    task automatic start_frame();
        frame_start_in = 1;
        tick();
        frame_start_in = 0;
    endtask

    task automatic test_reset();
        @(negedge pixel_clk_in);
        do_reset();
        total++; if (ray_ready_out !== 1'b0) $display("FAIL reset_ready: got %b want 0", ray_ready_out); else passed++;
        total++; if (dda_fifo_tvalid_out !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", dda_fifo_tvalid_out); else passed++;
        total++; if (dda_fifo_tdata_out !== 38'd0) $display("FAIL reset_tdata: got %h want 0", dda_fifo_tdata_out); else passed++;
        total++; if (dda_fifo_tlast_out !== 1'b0) $display("FAIL reset_tlast: got %b want 0", dda_fifo_tlast_out); else passed++;
        total++; if (frame_done_out !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done_out); else passed++;
        total++; if (overflow_err_out !== 1'b0) $display("FAIL reset_err: got %b want 0", overflow_err_out); else passed++;
    endtask

    task automatic test_full_frame();
        int next_col = 0;
        int done_cnt = 0;
        do_reset();
        start_frame();
        total++; if (ray_ready_out !== 1'b1) $display("FAIL start_latency: ready got %b want 1", ray_ready_out); else passed++;
        dda_fifo_tready_in = 1;
        ray_valid_in = 1;
        for (int c = 0; c < 330; c++) begin
            rand_ray();
            if (m_col == 5) begin
                ray_line_height_in = 8'd100;
                ray_wall_type_in = 1'b1;
                ray_map_data_in = 4'd3;
                ray_wallX_in = 16'h8000;
            end
            total++; if (ray_ready_out !== (m_phase == M_ACTIVE && m_q.size() < D)) $display("FAIL frame_ready c%0d: got %b", c, ray_ready_out); else passed++;
            total++; if (dda_fifo_tvalid_out !== (m_q.size() > 0)) $display("FAIL frame_tvalid c%0d: got %b want %0d", c, dda_fifo_tvalid_out, m_q.size() > 0); else passed++;
            total++; if (frame_done_out !== m_done) $display("FAIL frame_done c%0d: got %b want %b", c, frame_done_out, m_done); else passed++;
            total++; if (overflow_err_out !== 1'b0) $display("FAIL frame_err c%0d: got %b want 0", c, overflow_err_out); else passed++;
            if (frame_done_out) done_cnt++;
            if (m_q.size() > 0) begin
                total++; if (dda_fifo_tdata_out !== m_q[0][37:0]) $display("FAIL frame_tdata c%0d: got %h want %h", c, dda_fifo_tdata_out, m_q[0][37:0]); else passed++;
                total++; if (dda_fifo_tdata_out[37:29] !== 9'(next_col)) $display("FAIL frame_col: got %0d want %0d", dda_fifo_tdata_out[37:29], next_col); else passed++;
                total++; if (dda_fifo_tlast_out !== (next_col == W - 1)) $display("FAIL frame_tlast col%0d: got %b", next_col, dda_fifo_tlast_out); else passed++;
                if (next_col == 5) begin
                    total++; if (dda_fifo_tdata_out !== {9'd5, 8'd100, 1'b1, 4'd3, 16'h8000}) $display("FAIL col5_packet: got %h want %h", dda_fifo_tdata_out, {9'd5, 8'd100, 1'b1, 4'd3, 16'h8000}); else passed++;
                end
                next_col++;
            end
            tick();
        end
        ray_valid_in = 0;
        total++; if (next_col !== W) $display("FAIL frame_count: got %0d want %0d", next_col, W); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL frame_done_count: got %0d want 1", done_cnt); else passed++;
        total++; if (ray_ready_out !== 1'b0) $display("FAIL frame_idle_ready: got %b want 0", ray_ready_out); else passed++;
    endtask

    task automatic test_backpressure();
        logic [37:0] head;
        int beats = 0;
        do_reset();
        start_frame();
        dda_fifo_tready_in = 0;
        ray_valid_in = 1;
        for (int i = 0; i < 10; i++) begin
            rand_ray();
            total++; if (ray_ready_out !== (i < D)) $display("FAIL bp_ready i%0d: got %b want %b", i, ray_ready_out, i < D); else passed++;
            if (i >= 2) begin
                total++; if (dda_fifo_tdata_out !== head) $display("FAIL bp_head_stable i%0d: got %h want %h", i, dda_fifo_tdata_out, head); else passed++;
            end
            tick();
            if (i == 0) head = m_q[0][37:0];
        end
        total++; if (overflow_err_out !== 1'b1) $display("FAIL bp_overflow: got %b want 1", overflow_err_out); else passed++;
        ray_valid_in = 0;
        dda_fifo_tready_in = 1;
        for (int i = 0; i < D + 2; i++) begin
            if (m_q.size() > 0) begin
                total++; if (dda_fifo_tdata_out !== m_q[0][37:0] || dda_fifo_tdata_out[37:29] !== 9'(beats)) $display("FAIL bp_drain beat%0d: got %h want %h", beats, dda_fifo_tdata_out, m_q[0][37:0]); else passed++;
            end
            if (dda_fifo_tvalid_out) beats++;
            tick();
        end
        total++; if (beats !== D) $display("FAIL bp_drain_count: got %0d want %0d", beats, D); else passed++;
        total++; if (dda_fifo_tvalid_out !== 1'b0) $display("FAIL bp_empty: tvalid got %b want 0", dda_fifo_tvalid_out); else passed++;
        total++; if (overflow_err_out !== 1'b1) $display("FAIL bp_sticky: got %b want 1", overflow_err_out); else passed++;
    endtask

    task automatic test_reset_mid();
        ray_valid_in = 1;
        dda_fifo_tready_in = 1;
        for (int i = 0; i < 300 && m_col != 150; i++) begin
            rand_ray();
            tick();
        end
        total++; if (m_col !== 150 || dda_fifo_tvalid_out !== 1'b1) $display("FAIL mid_reach150: col %0d tvalid %b", m_col, dda_fifo_tvalid_out); else passed++;
        total++; if (overflow_err_out !== 1'b1) $display("FAIL mid_sticky: got %b want 1", overflow_err_out); else passed++;
        rst_in = 1;
        tick();
        rst_in = 0;
        total++; if (ray_ready_out !== 1'b0 || dda_fifo_tvalid_out !== 1'b0) $display("FAIL mid_reset_hs: ready %b tvalid %b want 0 0", ray_ready_out, dda_fifo_tvalid_out); else passed++;
        total++; if (dda_fifo_tdata_out !== 38'd0 || dda_fifo_tlast_out !== 1'b0) $display("FAIL mid_reset_data: got %h/%b want 0", dda_fifo_tdata_out, dda_fifo_tlast_out); else passed++;
        total++; if (overflow_err_out !== 1'b0 || frame_done_out !== 1'b0) $display("FAIL mid_reset_flags: err %b done %b want 0 0", overflow_err_out, frame_done_out); else passed++;
        ray_valid_in = 0;
        start_frame();
        ray_valid_in = 1;
        rand_ray();
        tick();
        ray_valid_in = 0;
        total++; if (dda_fifo_tvalid_out !== 1'b1 || dda_fifo_tdata_out[37:29] !== 9'd0) $display("FAIL mid_restart_col: tvalid %b col %0d want 1 0", dda_fifo_tvalid_out, dda_fifo_tdata_out[37:29]); else passed++;
        total++; if (dda_fifo_tdata_out !== m_q[0][37:0]) $display("FAIL mid_restart_pkt: got %h want %h", dda_fifo_tdata_out, m_q[0][37:0]); else passed++;
    endtask

    task automatic test_clamp();
        logic [7:0] want250;
`ifdef DDA_TX_LINE_CLAMP_EN
        want250 = 8'd180;
`else
        want250 = 8'd250;
`endif
        do_reset();
        start_frame();
        ray_valid_in = 1;
        rand_ray();
        ray_line_height_in = 8'd250;
        tick();
        rand_ray();
        ray_line_height_in = 8'd120;
        tick();
        ray_valid_in = 0;
        total++; if (dda_fifo_tdata_out[28:21] !== want250) $display("FAIL clamp_250: got %0d want %0d", dda_fifo_tdata_out[28:21], want250); else passed++;
        dda_fifo_tready_in = 1;
        tick();
        total++; if (dda_fifo_tdata_out[28:21] !== 8'd120) $display("FAIL clamp_120: got %0d want 120", dda_fifo_tdata_out[28:21]); else passed++;
    endtask

    task automatic test_random();
        int c = 0;
        bit seen_done = 0;
        do_reset();
        start_frame();
        while (c < 3000 && !seen_done) begin
            ray_valid_in = ($urandom_range(0, 9) < 7);
            dda_fifo_tready_in = ($urandom_range(0, 9) < 6);
            frame_start_in = ($urandom_range(0, 19) == 0);
            rand_ray();
            total++; if (ray_ready_out !== (m_phase == M_ACTIVE && m_q.size() < D)) $display("FAIL rnd_ready c%0d: got %b", c, ray_ready_out); else passed++;
            total++; if (dda_fifo_tvalid_out !== (m_q.size() > 0)) $display("FAIL rnd_tvalid c%0d: got %b", c, dda_fifo_tvalid_out); else passed++;
            total++; if (overflow_err_out !== m_err || frame_done_out !== m_done) $display("FAIL rnd_flags c%0d: err %b done %b want %b %b", c, overflow_err_out, frame_done_out, m_err, m_done); else passed++;
            if (m_q.size() > 0) begin
                total++; if ({dda_fifo_tlast_out, dda_fifo_tdata_out} !== m_q[0]) $display("FAIL rnd_beat c%0d: got %h want %h", c, {dda_fifo_tlast_out, dda_fifo_tdata_out}, m_q[0]); else passed++;
            end
            if (frame_done_out) seen_done = 1;
            tick();
            c++;
        end
        frame_start_in = 0;
        ray_valid_in = 0;
        total++; if (!seen_done) $display("FAIL rnd_timeout: frame_done not seen in %0d cycles", c); else passed++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_reset_mid();
        test_clamp();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
